// File: rtl/ibex_zkn_aes_seq_pkg.sv
// Shared definitions for the sequential Zkn AES32 unit: state encoding, GF(2^8) helpers and the
// S-box affine maps.
package ibex_zkn_aes_seq_pkg;

  typedef logic [2:0] zkn_aes_seq_state_e;

  localparam zkn_aes_seq_state_e StIdle = 3'd0;
  localparam zkn_aes_seq_state_e StSbox = 3'd1;
  localparam zkn_aes_seq_state_e StMix  = 3'd2;
  localparam zkn_aes_seq_state_e StRot  = 3'd3;
  localparam zkn_aes_seq_state_e StDone = 3'd4;

  // Low byte of the AES field polynomial 0x11B.
  localparam logic [7:0] AES_POLY = 8'h1B;

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul_const(input logic [7:0] a, input logic [7:0] c);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) r = r ^ p;
      p = gf_xtime(p);
    end
    return r;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul_const(p, p);
      r = gf_mul_const(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] b, input logic [2:0] n);
    return (b << n) | (b >> (4'd8 - {1'b0, n}));
  endfunction

  function automatic logic [7:0] aes_affine_fwd(input logic [7:0] b);
    return b ^ rol8(b, 3'd1) ^ rol8(b, 3'd2) ^ rol8(b, 3'd3) ^ rol8(b, 3'd4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] aes_affine_inv(input logic [7:0] b);
    return rol8(b, 3'd1) ^ rol8(b, 3'd3) ^ rol8(b, 3'd6) ^ 8'h05;
  endfunction

  function automatic logic [7:0] aes_mix_coef(input logic enc, input logic [1:0] k);
    logic [7:0] c;
    c = 8'h00;
    unique case (k)
      2'd0: c = enc ? 8'h02 : 8'h0E;
      2'd1: c = enc ? 8'h01 : 8'h09;
      2'd2: c = enc ? 8'h01 : 8'h0D;
      2'd3: c = enc ? 8'h03 : 8'h0B;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] rol32(input logic [31:0] w, input logic [4:0] sh);
    return (w << sh) | (w >> (6'd32 - {1'b0, sh}));
  endfunction

endpackage

// File: rtl/ibex_zkn_sbox.sv
// Combinational AES forward/inverse S-box built from the field inverse and affine maps.
module ibex_zkn_sbox
  import ibex_zkn_aes_seq_pkg::*;
#(
  parameter bit SBoxInvShared = 1'b1
) (
  input  logic [7:0] x_i,
  input  logic       inv_i,
  output logic [7:0] s_o
);

  if (SBoxInvShared) begin : g_shared
    // One inverter serves both directions; the affine maps sit on opposite sides of it.
    logic [7:0] inv_in;
    logic [7:0] inv_out;
    assign inv_in  = inv_i ? aes_affine_inv(x_i) : x_i;
    assign inv_out = gf_inv(inv_in);
    assign s_o     = inv_i ? inv_out : aes_affine_fwd(inv_out);
  end else begin : g_split
    logic [7:0] s_fwd;
    logic [7:0] s_inv;
    assign s_fwd = aes_affine_fwd(gf_inv(x_i));
    assign s_inv = gf_inv(aes_affine_inv(x_i));
    assign s_o   = inv_i ? s_inv : s_fwd;
  end

endmodule

// File: rtl/ibex_zkn_aes_seq.sv
// Multi-cycle AES32 ES/ESM/DS/DSM responder; builds the (Inv)MixColumn word one byte per cycle
// with a single shared constant multiplier.
module ibex_zkn_aes_seq
  import ibex_zkn_aes_seq_pkg::*;
#(
  parameter bit SBoxInvShared = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        abort_i,
  input  logic        ready_i,
  input  logic [1:0]  bs_i,
  input  logic        mr_i,
  input  logic        enc_dec_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  output logic        busy_o,
  output logic        valid_o,
  output logic [31:0] result_o
);

  zkn_aes_seq_state_e state_q, state_d;
  logic [31:0] rs1_q, rs1_d;
  logic [7:0]  x_q, x_d;
  logic [1:0]  bs_q, bs_d;
  logic        mr_q, mr_d;
  logic        enc_q, enc_d;
  logic [7:0]  s_q, s_d;
  logic [1:0]  k_q, k_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] result_q, result_d;
  logic [7:0]  sbox_out;

  ibex_zkn_sbox #(
    .SBoxInvShared(SBoxInvShared)
  ) u_sbox (
    .x_i  (x_q),
    .inv_i(~enc_q),
    .s_o  (sbox_out)
  );

  always_comb begin
    state_d  = state_q;
    rs1_d    = rs1_q;
    x_d      = x_q;
    bs_d     = bs_q;
    mr_d     = mr_q;
    enc_d    = enc_q;
    s_d      = s_q;
    k_d      = k_q;
    acc_d    = acc_q;
    result_d = result_q;

    unique case (state_q)
      StIdle: begin
        if (en_i && !abort_i) begin
          rs1_d   = rs1_i;
          x_d     = rs2_i[{bs_i, 3'b000} +: 8];
          bs_d    = bs_i;
          mr_d    = mr_i;
          enc_d   = enc_dec_i;
          state_d = StSbox;
        end
      end
      StSbox: begin
        s_d = sbox_out;
        if (mr_q) begin
          acc_d   = 32'h0;
          k_d     = 2'd0;
          state_d = StMix;
        end else begin
          acc_d   = {24'h0, sbox_out};
          state_d = StRot;
        end
      end
      StMix: begin
        acc_d[{k_q, 3'b000} +: 8] = gf_mul_const(s_q, aes_mix_coef(enc_q, k_q));
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) state_d = StRot;
      end
      StRot: begin
        result_d = rs1_q ^ rol32(acc_q, {bs_q, 3'b000});
        state_d  = StDone;
      end
      StDone: begin
        if (ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A kill leaves the last delivered result in place.
    if (abort_i && (state_q != StIdle)) begin
      state_d  = StIdle;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      rs1_q    <= 32'h0;
      x_q      <= 8'h0;
      bs_q     <= 2'd0;
      mr_q     <= 1'b0;
      enc_q    <= 1'b0;
      s_q      <= 8'h0;
      k_q      <= 2'd0;
      acc_q    <= 32'h0;
      result_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      rs1_q    <= rs1_d;
      x_q      <= x_d;
      bs_q     <= bs_d;
      mr_q     <= mr_d;
      enc_q    <= enc_d;
      s_q      <= s_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = (state_q != StIdle);
  assign valid_o  = (state_q == StDone);
  assign result_o = result_q;

endmodule

// File: tb/tb_ibex_zkn_aes_seq.sv
// Randomised and directed checks of ibex_zkn_aes_seq against a table-driven AES reference model.
module tb_ibex_zkn_aes_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        abort;
  logic        ready;
  logic [1:0]  bs;
  logic        mr;
  logic        enc_dec;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy;
  logic        valid;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] sbox_tbl [256];
  logic [7:0] isbox_tbl[256];

  ibex_zkn_aes_seq dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .en_i     (en),
    .abort_i  (abort),
    .ready_i  (ready),
    .bs_i     (bs),
    .mr_i     (mr),
    .enc_dec_i(enc_dec),
    .rs1_i    (rs1),
    .rs2_i    (rs2),
    .busy_o   (busy),
    .valid_o  (valid),
    .result_o (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_rol8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r = 0;
    while (b != 0) begin
      if (b[0]) r = r ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1B) : (a << 1);
      b = b >> 1;
    end
    return r;
  endfunction

  // Builds the S-box by walking the multiplicative group with generator 3 and its inverse.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1B : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ m_rol8(q, 1) ^ m_rol8(q, 2) ^ m_rol8(q, 3) ^ m_rol8(q, 4);
      sbox_tbl[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_tbl[0] = 8'h63;
    for (int i = 0; i < 256; i++) isbox_tbl[sbox_tbl[i]] = 8'(i);
  endtask

  function automatic logic [31:0] model(input logic e, input logic m, input logic [1:0] b,
                                        input logic [31:0] a1, input logic [31:0] a2);
    logic [7:0] x, s;
    logic [7:0] w  [4];
    logic [7:0] cf [4];
    logic [31:0] r;
    x = 8'(a2 >> (8 * b));
    s = e ? sbox_tbl[x] : isbox_tbl[x];
    if (e) cf = '{8'h02, 8'h01, 8'h01, 8'h03};
    else   cf = '{8'h0E, 8'h09, 8'h0D, 8'h0B};
    for (int i = 0; i < 4; i++) w[i] = m ? m_mul(s, cf[i]) : ((i == 0) ? s : 8'h00);
    r = 0;
    for (int i = 0; i < 4; i++) r[8 * ((i + b) % 4) +: 8] = w[i];
    return r ^ a1;
  endfunction

  task automatic scramble_ops();
    bs      = 2'($urandom);
    mr      = 1'($urandom);
    enc_dec = 1'($urandom);
    rs1     = $urandom;
    rs2     = $urandom;
  endtask

  // Issue one op in IDLE; returns at the negedge of the cycle following capture.
  task automatic start_op(input logic e, input logic m, input logic [1:0] b,
                          input logic [31:0] a1, input logic [31:0] a2);
    en = 1'b1; enc_dec = e; mr = m; bs = b; rs1 = a1; rs2 = a2;
    @(negedge clk);
    en = 1'b0;
    scramble_ops();
  endtask

  task automatic wait_valid(input string tag, input int exp_lat);
    int lat;
    lat = 1;
    while (!valid && lat < 20) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      en = 1'($urandom);
      scramble_ops();
      @(negedge clk);
      lat++;
    end
    en = 1'b0;
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic release_op(input string tag, input int hold);
    for (int i = 0; i < hold; i++) @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check({tag, "_idle"}, {30'd0, busy, valid}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic e, input logic m, input logic [1:0] b,
                        input logic [31:0] a1, input logic [31:0] a2, input logic [31:0] exp);
    start_op(e, m, b, a1, a2);
    wait_valid(tag, m ? 7 : 3);
    check({tag, "_res"}, result, exp);
    release_op(tag, 0);
  endtask

  initial begin
    logic [31:0] held, e_res;
    logic e, m;
    logic [1:0] b;
    logic [31:0] a1, a2;

    build_sbox();
    rst = 1'b1; en = 1'b0; abort = 1'b0; ready = 1'b0;
    scramble_ops();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_out", {busy, valid, result}, 34'd0);

    // Directed vectors with hand-derived results.
    run_op("es0",   1'b1, 1'b0, 2'd0, 32'h0,        32'h0,        32'h0000_0063);
    run_op("esm0",  1'b1, 1'b1, 2'd0, 32'h0,        32'h0,        32'hA563_63C6);
    run_op("esm1",  1'b1, 1'b1, 2'd1, 32'h0,        32'h0,        32'h6363_C6A5);
    run_op("dsm0",  1'b0, 1'b1, 2'd0, 32'h0,        32'h0,        32'h50A7_F451);
    run_op("dsmf",  1'b0, 1'b1, 2'd0, 32'hFFFF_FFFF, 32'h0,       32'hAF58_0BAE);
    run_op("ds3",   1'b0, 1'b0, 2'd3, 32'h1234_5678, 32'h6300_0000, 32'h1234_5678);

    // Hold DONE with en_i asserted: outputs stay stable and no new op starts.
    start_op(1'b1, 1'b1, 2'd2, 32'hDEAD_BEEF, 32'h00C0_0000);
    wait_valid("hold", 7);
    held = model(1'b1, 1'b1, 2'd2, 32'hDEAD_BEEF, 32'h00C0_0000);
    check("hold_res", result, held);
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      scramble_ops();
      @(negedge clk);
      check("hold_valid", 32'(valid), 32'd1);
      check("hold_stable", result, held);
    end
    en = 1'b0;
    release_op("hold", 0);
    // Op accepted straight from the released IDLE cycle.
    run_op("after_rel", 1'b1, 1'b0, 2'd1, 32'h0F0F_0F0F, 32'h0000_5300,
           model(1'b1, 1'b0, 2'd1, 32'h0F0F_0F0F, 32'h0000_5300));

    // abort_i beats en_i in IDLE.
    en = 1'b1; abort = 1'b1;
    @(negedge clk);
    en = 1'b0; abort = 1'b0;
    check("idle_abort", 32'(busy), 32'd0);

    // Abort during MIX with k=2: back to IDLE, result untouched, no valid.
    held = result;
    start_op(1'b0, 1'b1, 2'd0, 32'h1111_2222, 32'h0000_00AB);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check("abort_novalid", 32'(valid), 32'd0);
      check("abort_res", result, held);
      @(negedge clk);
    end

    // Reset mid-MIX clears everything.
    start_op(1'b1, 1'b1, 2'd0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_out", {busy, valid, result}, 34'd0);
    repeat (8) begin
      @(negedge clk);
      check("midrst_novalid", 32'(valid), 32'd0);
    end

    // Randomised ops against the reference model.
    for (int t = 0; t < 40; t++) begin
      e  = 1'($urandom);
      m  = 1'($urandom);
      b  = 2'($urandom);
      a1 = $urandom;
      a2 = $urandom;
      e_res = model(e, m, b, a1, a2);
      start_op(e, m, b, a1, a2);
      wait_valid("rnd", m ? 7 : 3);
      check("rnd_res", result, e_res);
      release_op("rnd", int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
